// File: rtl/servo_pwm_posicao.sv
// Servo PWM generator: renders a latched position code as a pulse width and
// emits the step strobe that advances the upstream sweep counter.
module servo_pwm_posicao #(
  parameter int N            = 3,
  parameter int PERIODO      = 1000000,
  parameter int LARGURA_MIN  = 50000,
  parameter int PASSO        = 7143,
  parameter int PERIODOS_POS = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         liga,
  input  logic [N-1:0] posicao,
  output logic         pwm,
  output logic         fim_periodo,
  output logic         avanca,
  output logic [N-1:0] posicao_ativa,
  output logic         ocupado
);

  localparam int CW = (PERIODO > 1) ? $clog2(PERIODO) : 1;
  localparam int PW = (PERIODOS_POS > 1) ? $clog2(PERIODOS_POS) : 1;
  localparam logic [CW-1:0] CNT_FIM = CW'(PERIODO - 1);
  localparam logic [PW-1:0] PER_FIM = PW'(PERIODOS_POS - 1);

  // The widest pulse must still leave a low phase inside the period.
  if (LARGURA_MIN + (2**N - 1) * PASSO >= PERIODO) begin : g_largura_invalida
    $error("servo_pwm_posicao: maximum pulse width does not fit in PERIODO");
  end

  typedef enum logic {PARADO, ATIVO} estado_t;

  estado_t        estado_q, estado_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  per_q, per_d;
  logic [CW-1:0]  largura_q, largura_d;
  logic [N-1:0]   pos_q, pos_d;
  logic           pwm_q, pwm_d;
  logic           fim_q, fim_d;
  logic           avanca_q, avanca_d;
  logic           ocupado_q, ocupado_d;
  logic           wrap;

  // Computed wide and then narrowed; the range check above keeps it in CW bits.
  function automatic logic [CW-1:0] calc_largura(input logic [N-1:0] p);
    return CW'(64'(LARGURA_MIN) + 64'(p) * 64'(PASSO));
  endfunction

  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    per_d     = per_q;
    largura_d = largura_q;
    pos_d     = pos_q;
    wrap      = (estado_q == ATIVO) && (cnt_q == CNT_FIM);

    case (estado_q)
      PARADO: begin
        if (liga) begin
          estado_d  = ATIVO;
          cnt_d     = '0;
          per_d     = '0;
          pos_d     = posicao;
          largura_d = calc_largura(posicao);
        end
      end
      default: begin
        if (wrap) begin
          cnt_d = '0;
          per_d = (per_q == PER_FIM) ? '0 : per_q + 1'b1;
          if (liga) begin
            pos_d     = posicao;
            largura_d = calc_largura(posicao);
          end else begin
            estado_d  = PARADO;
            per_d     = '0;
            pos_d     = '0;
            largura_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase

    // Outputs are derived from next-state values so they are plain flops.
    ocupado_d = (estado_d == ATIVO);
    pwm_d     = ocupado_d && (cnt_d < largura_d);
    fim_d     = ocupado_d && (cnt_d == CNT_FIM);
    avanca_d  = fim_d && (per_d == PER_FIM);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q  <= PARADO;
      cnt_q     <= '0;
      per_q     <= '0;
      largura_q <= '0;
      pos_q     <= '0;
      pwm_q     <= 1'b0;
      fim_q     <= 1'b0;
      avanca_q  <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      largura_q <= largura_d;
      pos_q     <= pos_d;
      pwm_q     <= pwm_d;
      fim_q     <= fim_d;
      avanca_q  <= avanca_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign pwm           = pwm_q;
  assign fim_periodo   = fim_q;
  assign avanca        = avanca_q;
  assign posicao_ativa = pos_q;
  assign ocupado       = ocupado_q;

endmodule

// File: tb/tb_servo_pwm_posicao.sv
// Directed bench for servo_pwm_posicao with a small up/down sweep counter
// model closing the avanca -> posicao loop.
module tb_servo_pwm_posicao;

  localparam int N   = 3;
  localparam int PER = 20;
  localparam int LMIN = 2;
  localparam int PAS = 2;
  localparam int PP  = 2;

  logic         clock = 1'b0;
  logic         reset;
  logic         liga;
  logic [N-1:0] pos_dir;
  logic         use_loop;
  logic [N-1:0] posicao;
  logic         pwm, fim_periodo, avanca, ocupado;
  logic [N-1:0] posicao_ativa;

  logic [N-1:0] q_cnt;
  logic         sobe;

  int checks = 0;
  int errors = 0;
  int tb_per = 0;

  servo_pwm_posicao #(
    .N(N), .PERIODO(PER), .LARGURA_MIN(LMIN), .PASSO(PAS), .PERIODOS_POS(PP)
  ) dut (
    .clock(clock), .reset(reset), .liga(liga), .posicao(posicao),
    .pwm(pwm), .fim_periodo(fim_periodo), .avanca(avanca),
    .posicao_ativa(posicao_ativa), .ocupado(ocupado)
  );

  always #5 clock = ~clock;

  assign posicao = use_loop ? q_cnt : pos_dir;

  // Sweep counter: 0..7 then back down to 0, stepping on each avanca.
  always @(posedge clock) begin
    if (reset) begin
      q_cnt <= '0;
      sobe  <= 1'b1;
    end else if (avanca) begin
      if (sobe) begin
        if (q_cnt == 3'd7) begin
          q_cnt <= 3'd6;
          sobe  <= 1'b0;
        end else q_cnt <= q_cnt + 3'd1;
      end else begin
        if (q_cnt == 3'd0) begin
          q_cnt <= 3'd1;
          sobe  <= 1'b1;
        end else q_cnt <= q_cnt - 3'd1;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pwm"}, 32'(pwm), 0);
    chk({tag, "_fim"}, 32'(fim_periodo), 0);
    chk({tag, "_avanca"}, 32'(avanca), 0);
    chk({tag, "_ocupado"}, 32'(ocupado), 0);
    chk({tag, "_posicao_ativa"}, 32'(posicao_ativa), 0);
  endtask

  // Checks one full period rendered at position pos, starting at its cnt=0 cycle.
  // nxt is applied at cnt=3 and liga_nxt at cnt=5, both mid-period.
  task automatic check_period(input int pos, input int nxt, input logic liga_nxt);
    int w;
    w = LMIN + pos * PAS;
    for (int i = 0; i < PER; i++) begin
      if (i == 3) pos_dir = 3'(nxt);
      if (i == 5) liga = liga_nxt;
      chk("pwm", 32'(pwm), 32'(i < w));
      chk("fim_periodo", 32'(fim_periodo), 32'(i == PER - 1));
      chk("avanca", 32'(avanca), 32'((i == PER - 1) && (tb_per == PP - 1)));
      chk("ocupado", 32'(ocupado), 1);
      chk("posicao_ativa", 32'(posicao_ativa), 32'(pos));
      step();
    end
    tb_per = liga_nxt ? (tb_per + 1) % PP : 0;
  endtask

  initial begin
    int seq;
    reset    = 1'b1;
    liga     = 1'b1;
    pos_dir  = 3'd0;
    use_loop = 1'b0;

    // Reset dominates a high liga
    step();
    chk_zero("rst1");
    step();
    chk_zero("rst2");
    reset = 1'b0;
    step();
    chk("start_pwm", 32'(pwm), 1);
    chk("start_ocupado", 32'(ocupado), 1);
    tb_per = 0;

    // Widths 2, 16, 8 over three periods each; strobes checked throughout
    check_period(0, 0, 1'b1);
    check_period(0, 0, 1'b1);
    check_period(0, 7, 1'b1);
    check_period(7, 7, 1'b1);
    check_period(7, 7, 1'b1);
    check_period(7, 3, 1'b1);
    check_period(3, 3, 1'b1);
    check_period(3, 3, 1'b1);
    check_period(3, 1, 1'b1);

    // Mid-period change 1 -> 5 keeps width 4 until the wrap
    check_period(1, 5, 1'b1);
    check_period(5, 5, 1'b1);

    // Stop: liga dropped at cnt=5, period completes, then idle
    check_period(5, 5, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk_zero("parado");
      step();
    end

    // Loop with sweep counter, reset while pwm is high
    use_loop = 1'b1;
    liga = 1'b1;
    step();
    step();
    chk("loop_pre_reset_pwm", 32'(pwm), 1);
    reset = 1'b1;
    step();
    chk_zero("loop_reset");
    reset = 1'b0;
    step();
    tb_per = 0;
    // Code 0 is latched at entry and again at the wrap where the first avanca
    // fires (Q updates on that same edge), so it shows for one extra period.
    check_period(0, 0, 1'b1);
    check_period(0, 0, 1'b1);
    check_period(0, 0, 1'b1);
    for (int k = 1; k <= 14; k++) begin
      seq = (k <= 7) ? k : 14 - k;
      check_period(seq, 0, 1'b1);
      check_period(seq, 0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
